// File: rtl/rvfi_pkg.sv
// RVFI commit record as produced by the core's RVFI output.
// Only the fields consumed by the trace serializer plus the usual
// companions are carried; widths follow an RV64 core with Sv39.
package rvfi_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned VLEN = 39;

   typedef struct packed {
      logic             valid;
      logic [63:0]      order;
      logic [31:0]      insn;
      logic             trap;
      logic             halt;
      logic             intr;
      logic [1:0]       mode;
      logic [1:0]       ixl;
      logic [4:0]       rs1_addr;
      logic [4:0]       rs2_addr;
      logic [4:0]       rd_addr;
      logic [XLEN-1:0]  rd_wdata;
      logic [VLEN-1:0]  pc_rdata;
      logic [VLEN-1:0]  pc_wdata;
   } rvfi_instr_t;

endpackage

// File: rtl/rvfi_trace_pkg.sv
// Types and helpers for the RVFI trace serializer.
//   trace_rec_t  : one packed trace record as delivered to the sink
//   is_fp_dest() : true when the instruction writes an FP register
package rvfi_trace_pkg;

   localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

   // Opcodes whose destination is always an FP register
   localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
   localparam logic [6:0] OPC_MADD    = 7'b1000011;
   localparam logic [6:0] OPC_MSUB    = 7'b1000111;
   localparam logic [6:0] OPC_NMSUB   = 7'b1001011;
   localparam logic [6:0] OPC_NMADD   = 7'b1001111;
   localparam logic [6:0] OPC_OP_FP   = 7'b1010011;

   // OP-FP groups (insn[31:26]) that write an integer register
   localparam logic [5:0] F6_FMV_X_FCLASS = 6'b111000;
   localparam logic [5:0] F6_FCMP         = 6'b101000;
   localparam logic [5:0] F6_FCVT_TO_INT  = 6'b110000;

   typedef struct packed {
      logic [7:0]  hart;
      logic [31:0] cycle;
      logic [63:0] seq;
      logic [63:0] pc;
      logic [31:0] insn;
      logic [1:0]  mode;
      logic [4:0]  rd_addr;
      logic [63:0] rd_wdata;
      logic        rd_is_fp;
      logic        trap;
   } trace_rec_t;

   function automatic logic is_fp_dest(input logic [31:0] insn);
      logic [6:0] opc;
      logic [5:0] f6;
      opc = insn[6:0];
      f6  = insn[31:26];
      case (opc)
         OPC_LOAD_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD:
            return 1'b1;
         OPC_OP_FP:
            return !((f6 == F6_FMV_X_FCLASS) || (f6 == F6_FCMP) ||
                     (f6 == F6_FCVT_TO_INT));
         default:
            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Multi-push, single-pop FIFO of trace records.
//   push_valid_i : per-port record present
//   push_data_i  : per-port record
//   push_cnt_i   : number of present records (in port order) to store;
//                  the caller limits it to free_o
//   pop_i        : consume the head record (ignored when empty)
//   head_o       : head record, all-zero while empty
//   empty_o      : no record buffered
//   level_o      : registered occupancy
//   free_o       : DEPTH - level_o
module rvfi_trace_fifo
   import rvfi_trace_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned NR_PORTS = 2,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned LW      = AW + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NR_PORTS-1:0] push_valid_i,
   input  trace_rec_t          push_data_i [NR_PORTS],
   input  logic [LW-1:0]       push_cnt_i,
   input  logic                pop_i,
   output trace_rec_t          head_o,
   output logic                empty_o,
   output logic [LW-1:0]       level_o,
   output logic [LW-1:0]       free_o
);

   trace_rec_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] slot_ofs [NR_PORTS];
   logic [NR_PORTS-1:0] accept;
   logic          pop_eff;

   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign free_o  = LW'(DEPTH) - level_q;
   assign pop_eff = pop_i && !empty_o;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Each present record gets the next slot after the present records on
   // lower ports; only the first push_cnt_i of them are written.
   always_comb begin
      logic [LW-1:0] ofs;
      ofs    = '0;
      accept = '0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         slot_ofs[i] = ofs;
         if (push_valid_i[i]) begin
            accept[i] = (ofs < push_cnt_i);
            ofs       = ofs + LW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         if (accept[i]) begin
            mem_q[wr_ptr_q + slot_ofs[i][AW-1:0]] <= push_data_i[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + push_cnt_i[AW-1:0];
         rd_ptr_q <= rd_ptr_q + AW'(pop_eff);
         level_q  <= level_q + push_cnt_i - LW'(pop_eff);
      end
   end

endmodule

// File: rtl/rvfi_trace_serializer.sv
// Packs per-cycle RVFI commits into sequence-numbered, timestamped trace
// records and drains them one per cycle over valid/ready.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   rvfi_i         : NR_COMMIT_PORTS commit ports
//   trace_valid_o  : head record available
//   trace_ready_i  : sink accepts the head record
//   trace_o        : head record
//   instret_o      : valid commits since reset
//   drop_cnt_o     : records lost to overflow (saturating)
//   overflow_o     : sticky, some record was dropped
//   hang_o         : sticky, no valid commit for TIMEOUT_CYCLES cycles
//   halt_o         : sticky, ecall committed (HALT_ON_ECALL only)
//   level_o        : FIFO occupancy
module rvfi_trace_serializer
   import rvfi_trace_pkg::*;
#(
   parameter logic [7:0]  HART_ID         = 8'h00,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 100000,
   parameter logic        HALT_ON_ECALL   = 1'b0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  rvfi_pkg::rvfi_instr_t         rvfi_i [NR_COMMIT_PORTS],
   output logic                          trace_valid_o,
   input  logic                          trace_ready_i,
   output trace_rec_t                    trace_o,
   output logic [63:0]                   instret_o,
   output logic [31:0]                   drop_cnt_o,
   output logic                          overflow_o,
   output logic                          hang_o,
   output logic                          halt_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PW    = $clog2(NR_COMMIT_PORTS + 1);
   localparam int unsigned VLEN  = rvfi_pkg::VLEN;
   localparam logic [31:0] WD_LIMIT = TIMEOUT_CYCLES;
   localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);

   logic [31:0] cycle_q;
   logic [63:0] instret_q;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic        overflow_q, hang_q, hang_d, halt_q;
   logic [31:0] wd_q, wd_d;

   trace_rec_t                 recs [NR_COMMIT_PORTS];
   logic [NR_COMMIT_PORTS-1:0] rec_valid;
   logic [PW-1:0]              nvalid, nrec, ndrop;
   logic                       any_ecall;
   logic [LW-1:0]              push_cnt, free_cnt;
   logic                       fifo_empty;
   logic [32:0]                drop_sum;
   logic                       unused_rvfi;

   // Record building: seq for every record is instret plus the valid
   // commits on lower ports, so trap-only records share the number of the
   // next valid commit without consuming it.
   always_comb begin
      nvalid      = '0;
      nrec        = '0;
      rec_valid   = '0;
      any_ecall   = 1'b0;
      unused_rvfi = 1'b0;
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
         recs[i]          = '0;
         recs[i].hart     = HART_ID;
         recs[i].cycle    = cycle_q;
         recs[i].seq      = instret_q + 64'(nvalid);
         recs[i].pc       = {{(64 - VLEN){rvfi_i[i].pc_rdata[VLEN-1]}},
                             rvfi_i[i].pc_rdata};
         recs[i].insn     = rvfi_i[i].insn;
         recs[i].mode     = rvfi_i[i].mode;
         recs[i].rd_addr  = rvfi_i[i].rd_addr;
         recs[i].rd_wdata = rvfi_i[i].rd_wdata;
         recs[i].rd_is_fp = is_fp_dest(rvfi_i[i].insn);
         recs[i].trap     = rvfi_i[i].trap;
         rec_valid[i]     = rvfi_i[i].valid | rvfi_i[i].trap;
         if (rec_valid[i]) begin
            nrec = nrec + PW'(1);
         end
         if (rvfi_i[i].valid) begin
            nvalid = nvalid + PW'(1);
            if (rvfi_i[i].insn == ECALL_INSN) begin
               any_ecall = 1'b1;
            end
         end
         unused_rvfi = unused_rvfi ^ (^{rvfi_i[i].order, rvfi_i[i].halt,
                                        rvfi_i[i].intr, rvfi_i[i].ixl,
                                        rvfi_i[i].rs1_addr, rvfi_i[i].rs2_addr,
                                        rvfi_i[i].pc_wdata});
      end
   end

   // Space is judged on occupancy at the start of the cycle; a same-cycle
   // pop does not make room.
   assign push_cnt = (LW'(nrec) > free_cnt) ? free_cnt : LW'(nrec);
   assign ndrop    = nrec - PW'(push_cnt);
   assign drop_sum = {1'b0, drop_cnt_q} + 33'(ndrop);
   assign drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];

   always_comb begin
      wd_d = wd_q;
      if (!WD_EN || (nvalid != '0)) begin
         wd_d = '0;
      end else if (wd_q != WD_LIMIT) begin
         wd_d = wd_q + 32'd1;
      end
   end

   assign hang_d = hang_q | (WD_EN && (wd_d == WD_LIMIT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q    <= '0;
         instret_q  <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
         wd_q       <= '0;
         hang_q     <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         cycle_q    <= cycle_q + 32'd1;
         instret_q  <= instret_q + 64'(nvalid);
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_q | (ndrop != '0);
         wd_q       <= wd_d;
         hang_q     <= hang_d;
         halt_q     <= halt_q | (HALT_ON_ECALL & any_ecall);
      end
   end

   rvfi_trace_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .NR_PORTS (NR_COMMIT_PORTS)
   ) i_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_valid_i (rec_valid),
      .push_data_i  (recs),
      .push_cnt_i   (push_cnt),
      .pop_i        (trace_ready_i),
      .head_o       (trace_o),
      .empty_o      (fifo_empty),
      .level_o      (level_o),
      .free_o       (free_cnt)
   );

   assign trace_valid_o = !fifo_empty;
   assign instret_o     = instret_q;
   assign drop_cnt_o    = drop_cnt_q;
   assign overflow_o    = overflow_q;
   assign hang_o        = hang_q;
   assign halt_o        = halt_q;

endmodule

// File: tb/tb_rvfi_trace_serializer.sv
module tb_rvfi_trace_serializer;
   import rvfi_trace_pkg::*;

   localparam logic [31:0] ADDI  = 32'h0000_0013;
   localparam logic [31:0] FLT_D = 32'hA205_10D3;
   localparam logic [31:0] FADDD = 32'h0220_82D3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   rvfi_pkg::rvfi_instr_t rvfi [2];
   logic                  trace_valid;
   logic                  trace_ready = 1'b0;
   trace_rec_t            trace;
   logic [63:0]           instret;
   logic [31:0]           drop_cnt;
   logic                  overflow, hang, halt;
   logic [2:0]            level;

   int total = 0;
   int bad   = 0;

   rvfi_trace_serializer #(
      .HART_ID         (8'h5A),
      .NR_COMMIT_PORTS (2),
      .FIFO_DEPTH      (4),
      .TIMEOUT_CYCLES  (10),
      .HALT_ON_ECALL   (1'b1)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rvfi_i        (rvfi),
      .trace_valid_o (trace_valid),
      .trace_ready_i (trace_ready),
      .trace_o       (trace),
      .instret_o     (instret),
      .drop_cnt_o    (drop_cnt),
      .overflow_o    (overflow),
      .hang_o        (hang),
      .halt_o        (halt),
      .level_o       (level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic v, input logic t,
                           input logic [38:0] pc, input logic [31:0] insn,
                           input logic [4:0] rd);
      rvfi[p]          = '0;
      rvfi[p].valid    = v;
      rvfi[p].trap     = t;
      rvfi[p].pc_rdata = pc;
      rvfi[p].insn     = insn;
      rvfi[p].rd_addr  = rd;
      rvfi[p].rd_wdata = {59'd0, rd} + 64'h1000;
      rvfi[p].mode     = 2'b11;
   endtask

   task automatic clr_ports();
      rvfi[0] = '0;
      rvfi[1] = '0;
   endtask

   task automatic do_reset();
      clr_ports();
      trace_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clr_ports();
      rst_n = 1'b0;
      tick();
      tick();
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", trace_valid); end
      total++; if (trace !== '0) begin bad++; $display("FAIL rst_trace: got %h want 0", trace); end
      total++; if ({instret, drop_cnt} !== '0) begin bad++; $display("FAIL rst_counters: got %h/%h want 0/0", instret, drop_cnt); end
      total++; if ({overflow, hang, halt, level} !== '0) begin bad++; $display("FAIL rst_flags: got %b want 0", {overflow, hang, halt, level}); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      trace_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_port(0, 1'b1, 1'b0, 39'h0_8000_0000 + 39'(4 * k), ADDI, 5'(k + 1));
         tick();
         total++; if (trace_valid !== 1'b1 || trace.seq !== 64'(k)) begin bad++; $display("FAIL single_seq%0d: got v=%b seq=%0d want v=1 seq=%0d", k, trace_valid, trace.seq, k); end
         total++; if (trace.cycle !== 32'(k) || trace.pc !== 64'h8000_0000 + 64'(4 * k)) begin bad++; $display("FAIL single_cyc_pc%0d: got %0d/%h want %0d/%h", k, trace.cycle, trace.pc, k, 64'h8000_0000 + 64'(4 * k)); end
      end
      total++; if (trace.hart !== 8'h5A || trace.rd_addr !== 5'd5 || trace.rd_wdata !== 64'h1005 || trace.rd_is_fp !== 1'b0) begin bad++; $display("FAIL single_fields: got %h/%0d/%h/%b want 5a/5/1005/0", trace.hart, trace.rd_addr, trace.rd_wdata, trace.rd_is_fp); end
      total++; if (instret !== 64'd5 || level !== 3'd1) begin bad++; $display("FAIL single_instret: got %0d lvl %0d want 5 lvl 1", instret, level); end
      clr_ports();
      tick();
      total++; if (trace_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL single_drain: got v=%b lvl=%0d want 0/0", trace_valid, level); end
   endtask

   task automatic test_dual();
      do_reset();
      set_port(0, 1'b1, 1'b0, 39'h100, FLT_D, 5'd1);
      set_port(1, 1'b1, 1'b0, 39'h104, FADDD, 5'd5);
      tick();
      clr_ports();
      total++; if (level !== 3'd2 || instret !== 64'd2) begin bad++; $display("FAIL dual_level: got %0d/%0d want 2/2", level, instret); end
      total++; if (trace.seq !== 64'd0 || trace.rd_is_fp !== 1'b0 || trace.insn !== FLT_D) begin bad++; $display("FAIL dual_first: got seq=%0d fp=%b insn=%h want 0/0/%h", trace.seq, trace.rd_is_fp, trace.insn, FLT_D); end
      tick();
      total++; if (trace.seq !== 64'd0) begin bad++; $display("FAIL dual_hold: got seq=%0d want 0", trace.seq); end
      trace_ready = 1'b1;
      tick();
      total++; if (trace.seq !== 64'd1 || trace.rd_is_fp !== 1'b1 || trace.rd_addr !== 5'd5 || trace.cycle !== 32'd0) begin bad++; $display("FAIL dual_second: got seq=%0d fp=%b rd=%0d cyc=%0d want 1/1/5/0", trace.seq, trace.rd_is_fp, trace.rd_addr, trace.cycle); end
      tick();
   endtask

   task automatic test_trap();
      do_reset();
      set_port(0, 1'b1, 1'b0, 39'h1000, ADDI, 5'd1);
      tick();
      set_port(0, 1'b0, 1'b1, 39'h40_0000_0000, 32'h0, 5'd0);
      tick();
      total++; if (instret !== 64'd1 || level !== 3'd2) begin bad++; $display("FAIL trap_instret: got %0d lvl %0d want 1 lvl 2", instret, level); end
      set_port(0, 1'b1, 1'b0, 39'h1004, ADDI, 5'd2);
      set_port(1, 1'b0, 1'b1, 39'h1008, 32'h0, 5'd0);
      tick();
      clr_ports();
      total++; if (instret !== 64'd2 || level !== 3'd4) begin bad++; $display("FAIL trap_level: got %0d lvl %0d want 2 lvl 4", instret, level); end
      trace_ready = 1'b1;
      tick();
      total++; if (trace.trap !== 1'b1 || trace.seq !== 64'd1 || trace.pc !== 64'hFFFF_FFC0_0000_0000) begin bad++; $display("FAIL trap_rec: got t=%b seq=%0d pc=%h want 1/1/ffffffc000000000", trace.trap, trace.seq, trace.pc); end
      tick();
      total++; if (trace.trap !== 1'b0 || trace.seq !== 64'd1) begin bad++; $display("FAIL trap_next: got t=%b seq=%0d want 0/1", trace.trap, trace.seq); end
      tick();
      total++; if (trace.trap !== 1'b1 || trace.seq !== 64'd2) begin bad++; $display("FAIL trap_hi: got t=%b seq=%0d want 1/2", trace.trap, trace.seq); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_port(0, 1'b1, 1'b0, 39'h2000 + 39'(8 * k), ADDI, 5'd3);
         set_port(1, 1'b1, 1'b0, 39'h2004 + 39'(8 * k), ADDI, 5'd4);
         tick();
      end
      clr_ports();
      total++; if (level !== 3'd4 || drop_cnt !== 32'd2 || overflow !== 1'b1) begin bad++; $display("FAIL bp_full: got lvl=%0d drop=%0d ovf=%b want 4/2/1", level, drop_cnt, overflow); end
      total++; if (instret !== 64'd6) begin bad++; $display("FAIL bp_instret: got %0d want 6", instret); end
      trace_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (trace_valid !== 1'b1 || trace.seq !== 64'(k)) begin bad++; $display("FAIL bp_drain%0d: got v=%b seq=%0d want 1/%0d", k, trace_valid, trace.seq, k); end
         tick();
      end
      set_port(0, 1'b1, 1'b0, 39'h3000, ADDI, 5'd7);
      tick();
      clr_ports();
      total++; if (trace.seq !== 64'd6 || drop_cnt !== 32'd2 || overflow !== 1'b1) begin bad++; $display("FAIL bp_resume: got seq=%0d drop=%0d ovf=%b want 6/2/1", trace.seq, drop_cnt, overflow); end
      tick();
   endtask

   task automatic test_watchdog_halt();
      do_reset();
      trace_ready = 1'b1;
      for (int k = 0; k < 9; k++) tick();
      total++; if (hang !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", hang); end
      tick();
      total++; if (hang !== 1'b1) begin bad++; $display("FAIL wd_expire: got %b want 1", hang); end
      set_port(0, 1'b1, 1'b0, 39'h4000, ADDI, 5'd1);
      tick();
      total++; if (hang !== 1'b1 || halt !== 1'b0) begin bad++; $display("FAIL wd_sticky: got hang=%b halt=%b want 1/0", hang, halt); end
      set_port(0, 1'b1, 1'b0, 39'h4004, ECALL_INSN, 5'd0);
      tick();
      total++; if (halt !== 1'b1 || trace.insn !== ECALL_INSN || trace.seq !== 64'd1) begin bad++; $display("FAIL halt_ecall: got halt=%b insn=%h seq=%0d want 1/73/1", halt, trace.insn, trace.seq); end
      set_port(0, 1'b1, 1'b0, 39'h4008, ADDI, 5'd2);
      tick();
      clr_ports();
      total++; if (halt !== 1'b1 || trace.seq !== 64'd2 || trace_valid !== 1'b1) begin bad++; $display("FAIL halt_continue: got halt=%b seq=%0d v=%b want 1/2/1", halt, trace.seq, trace_valid); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_port(0, 1'b1, 1'b0, 39'h5000, ADDI, 5'd1);
      set_port(1, 1'b1, 1'b0, 39'h5004, ADDI, 5'd2);
      tick();
      clr_ports();
      set_port(0, 1'b1, 1'b0, 39'h5008, ADDI, 5'd3);
      tick();
      clr_ports();
      total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_fill: got %0d want 3", level); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (trace_valid !== 1'b0 || level !== 3'd0 || trace !== '0) begin bad++; $display("FAIL mid_flush: got v=%b lvl=%0d want 0/0", trace_valid, level); end
      total++; if (instret !== 64'd0 || drop_cnt !== 32'd0) begin bad++; $display("FAIL mid_counters: got %0d/%0d want 0/0", instret, drop_cnt); end
      tick();
      rst_n = 1'b1;
      trace_ready = 1'b1;
      set_port(0, 1'b1, 1'b0, 39'h6000, ADDI, 5'd4);
      tick();
      clr_ports();
      total++; if (trace.seq !== 64'd0 || trace.cycle !== 32'd0 || level !== 3'd1) begin bad++; $display("FAIL mid_restart: got seq=%0d cyc=%0d lvl=%0d want 0/0/1", trace.seq, trace.cycle, level); end
      tick();
   endtask

   initial begin
      clr_ports();
      test_reset();
      test_single();
      test_dual();
      test_trap();
      test_backpressure();
      test_watchdog_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
